// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux_pkg;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  typedef logic [1:0] sel_t;
endpackage

// File: rtl/demux1to4_stream_if.sv
// Producer-side and consumer-side handshake bundle of the 1-to-4 demux.
// master = producer/consumers (drives inputs), slave = the demux block.
interface demux1to4_stream_if #(parameter int N = 32);
  import demux_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         in_data;
  sel_t                 in_sel;
  logic [NUM_CH-1:0]    out_valid;
  logic [NUM_CH-1:0]    out_ready;
  logic [NUM_CH*N-1:0]  out_data;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_out_slot.sv
// One-entry output register for one demux channel; 1-cycle load latency.
// Ready to load when empty or draining this cycle. DEMUX_STATS_EN adds a drain counter.
module demux_out_slot #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc,
  input  logic [N-1:0]     in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [N-1:0]     out_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [N-1:0] dat_q, dat_d;

  // Accept wins over drain so a simultaneous drain+accept keeps the slot full.
  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    if (acc) begin
      state_d = S_FULL;
      dat_d   = in_data;
    end else if (state_q == S_FULL && out_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign out_data  = dat_q;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_FULL && out_ready) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign xfer_cnt = cnt_q;
`endif
endmodule

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 valid/ready stream demux; 1-cycle latency into the selected channel.
// in_ready reflects only the selected channel, so a stalled channel never blocks the others.
// Optional per-channel transfer counters with DEMUX_STATS_EN.
module demux1to4_stream
  import demux_pkg::*;
#(
  parameter int N = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  demux1to4_stream_if.slave   bus
`ifdef DEMUX_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] xfer_cnt
`endif
);
  logic [NUM_CH-1:0]   vld;
  logic [NUM_CH*N-1:0] dat;
  logic [NUM_CH-1:0]   acc_oh;
  logic                in_rdy;

  assign in_rdy = !vld[bus.in_sel] | bus.out_ready[bus.in_sel];

  always_comb begin
    acc_oh = '0;
    if (bus.in_valid && in_rdy) acc_oh[bus.in_sel] = 1'b1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_out_slot #(.N(N), .CNT_W(CNT_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .acc       (acc_oh[k]),
      .in_data   (bus.in_data),
      .out_ready (bus.out_ready[k]),
      .out_valid (vld[k]),
      .out_data  (dat[k*N +: N])
`ifdef DEMUX_STATS_EN
      ,
      .xfer_cnt  (xfer_cnt[k*CNT_W +: CNT_W])
`endif
    );
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld;
  assign bus.out_data  = dat;
endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed bench for demux1to4_stream; define DEMUX_STATS_EN to also exercise the counters.
module tb_demux1to4_stream;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  demux1to4_stream_if #(.N(32)) bus();
`ifdef DEMUX_STATS_EN
  logic [63:0] xfer_cnt;
`endif

  demux1to4_stream #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DEMUX_STATS_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = 2'd0;
    bus.out_ready = 4'b0000;

    // Reset asserted mid-cycle, outputs checked before any edge
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", 128'(bus.out_valid), 128'h0);
    chk("rst_data",  128'(bus.out_data),  128'h0);
    chk("rst_ready", 128'(bus.in_ready),  128'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Route one word to each channel
    bus.out_ready = 4'b1111;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hAAAA_AAAA;
    bus.in_sel    = 2'd0;
    #1 chk("route_rdy", 128'(bus.in_ready), 128'h1);
    tick();
    chk("route0_vld", 128'(bus.out_valid), 128'h1);
    chk("route0_dat", 128'(bus.out_data[31:0]), 128'hAAAA_AAAA);
    bus.in_data = 32'hBBBB_BBBB; bus.in_sel = 2'd1;
    tick();
    chk("route1_vld", 128'(bus.out_valid), 128'h2);
    chk("route1_dat", 128'(bus.out_data[63:32]), 128'hBBBB_BBBB);
    bus.in_data = 32'hCCCC_CCCC; bus.in_sel = 2'd2;
    tick();
    chk("route2_vld", 128'(bus.out_valid), 128'h4);
    chk("route2_dat", 128'(bus.out_data[95:64]), 128'hCCCC_CCCC);
    bus.in_data = 32'hDDDD_DDDD; bus.in_sel = 2'd3;
    tick();
    chk("route3_vld", 128'(bus.out_valid), 128'h8);
    chk("route3_dat", 128'(bus.out_data[127:96]), 128'hDDDD_DDDD);
    bus.in_valid = 1'b0;
    tick();
    chk("drain_vld",  128'(bus.out_valid), 128'h0);
    chk("drain_hold", 128'(bus.out_data[127:96]), 128'hDDDD_DDDD);

    // Stall channel 2
    bus.out_ready = 4'b1011;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h1234_5678;
    bus.in_sel    = 2'd2;
    #1 chk("stall_rdy0", 128'(bus.in_ready), 128'h1);
    tick();
    chk("stall_vld", 128'(bus.out_valid), 128'h4);
    chk("stall_dat", 128'(bus.out_data[95:64]), 128'h1234_5678);
    bus.in_data = 32'h9ABC_DEF0;
    #1 chk("stall_rdy1", 128'(bus.in_ready), 128'h0);
    tick();
    chk("stall_held", 128'(bus.out_data[95:64]), 128'h1234_5678);
    chk("stall_rdy2", 128'(bus.in_ready), 128'h0);

    // Isolation: channel 0 accepts while channel 2 is stuck full
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'd0;
    tick();
    chk("idle_sel_vld", 128'(bus.out_valid), 128'h4);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h5555_5555;
    #1 chk("iso_rdy", 128'(bus.in_ready), 128'h1);
    tick();
    chk("iso_vld",  128'(bus.out_valid), 128'h5);
    chk("iso_dat0", 128'(bus.out_data[31:0]), 128'h5555_5555);
    chk("iso_dat2", 128'(bus.out_data[95:64]), 128'h1234_5678);

    // Release channel 2: drain and accept on the same edge
    bus.out_ready = 4'b1111;
    bus.in_data   = 32'h9ABC_DEF0;
    bus.in_sel    = 2'd2;
    #1 chk("rel_rdy", 128'(bus.in_ready), 128'h1);
    tick();
    chk("rel_vld", 128'(bus.out_valid), 128'h4);
    chk("rel_dat", 128'(bus.out_data[95:64]), 128'h9ABC_DEF0);
    bus.in_valid = 1'b0;
    tick();
    chk("rel_empty", 128'(bus.out_valid), 128'h0);

    // Back-to-back on channel 1
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 32'(i);
      #1 chk("b2b_rdy", 128'(bus.in_ready), 128'h1);
      tick();
      chk("b2b_dat", 128'(bus.out_data[63:32]), 128'(i));
      chk("b2b_vld", 128'(bus.out_valid), 128'h2);
    end
    bus.in_valid = 1'b0;

    // Reset mid-operation discards a held word
    bus.out_ready = 4'b0000;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hFEED_BEEF;
    bus.in_sel    = 2'd3;
    tick();
    bus.in_valid = 1'b0;
    chk("pre_rst_vld", 128'(bus.out_valid), 128'hA);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 128'(bus.out_valid), 128'h0);
    chk("mid_rst_rdy", 128'(bus.in_ready), 128'h1);
    chk("mid_rst_dat", 128'(bus.out_data), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

`ifdef DEMUX_STATS_EN
    chk("cnt_rst", 128'(xfer_cnt), 128'h0);
    bus.out_ready = 4'b1000;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'd3;
    for (int i = 0; i < 70000; i++) begin
      bus.in_data = 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("cnt3_wrap", 128'(xfer_cnt[63:48]), 128'd4464);
    chk("cnt_other", 128'(xfer_cnt[47:0]),  128'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
